button_scanner: RTL
===================

# button_scanner

Time-multiplexed debounce controller for the game's player buttons. It synchronizes `NUM_BUTTONS` raw inputs and samples them on a slow, divided sample tick. A single shared history-update engine is then sequenced round-robin across all buttons. The block outputs a stable level per button plus one-cycle press and release pulses for the paddle and game-state logic.

## Interface

Parameters:
- `NUM_BUTTONS`, default 4: number of button inputs (≥ 2).
- `HIST_LEN`, default 8: samples per button history (≥ 2).
- `TICK_DIV`, default 1000: clocks per sample tick. Must satisfy `TICK_DIV > NUM_BUTTONS + 1`; out-of-range values are a static configuration error.

Ports:
- `clk`, input, 1: system clock. All logic is in this single clock domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `buttons`, input, `NUM_BUTTONS`: raw asynchronous button levels, active high.
- `debounced`, output, `NUM_BUTTONS`: stable button levels.
- `pressed`, output, `NUM_BUTTONS`: one-cycle pulse when `debounced[k]` goes 0→1.
- `released`, output, `NUM_BUTTONS`: one-cycle pulse when `debounced[k]` goes 1→0.
- `busy`, output, 1: high while the scan sequence is running.

## Operation

- **Synchronizer:** a 2-flop synchronizer on every `buttons` bit. Only its output (`sync`) is sampled.
- **Tick counter:** `ceil(log2(TICK_DIV))` bits wide. It counts 0..`TICK_DIV`-1 and wraps to 0, running freely in every state. `tick` is high during the cycle in which the count equals `TICK_DIV`-1.
- **Per-button history:** one `HIST_LEN`-bit register per button.
- **FSM states:**
  - IDLE: on `tick`, set `idx` = 0 and go to SCAN.
  - SCAN: each cycle, process button `idx` (see below). If `idx == NUM_BUTTONS-1`, go to IDLE; otherwise increment `idx`.
- **Processing button k** (exactly one button per SCAN cycle):
  - `new_hist = {hist[k][HIST_LEN-2:0], sync[k]}`, then `hist[k] <= new_hist`.
  - If `new_hist` is all ones and `debounced[k] == 0`: set `debounced[k]` and pulse `pressed[k]`.
  - If `new_hist` is all zeros and `debounced[k] == 1`: clear `debounced[k]` and pulse `released[k]`.
  - Any mixed history holds `debounced[k]` unchanged (hysteresis).
- **Pulse outputs:** registered. `pressed` and `released` are zero in every cycle except the single cycle following the update of that button. At most one bit of `pressed | released` is high in any cycle.
- `busy` is high exactly while the FSM is in SCAN.
- By construction `tick` never occurs in SCAN, because `TICK_DIV > NUM_BUTTONS + 1`. No tick queuing is required.
- **Reset (asynchronous, any time including mid-scan):**
  - FSM to IDLE, `idx` = 0, tick counter = 0.
  - Synchronizer flops, all histories, `debounced`, `pressed`, `released` and `busy` = 0.
  - The next scan begins only after a full `TICK_DIV` period.

## Timing

- Cycle 0 is the first rising `clk` edge after `reset_n` deasserts. The counter value in cycle c is c mod `TICK_DIV`, so `tick` falls at cycles `TICK_DIV`-1, `2·TICK_DIV`-1, and so on.
- For a tick in cycle T:
  - SCAN occupies cycles T+1..T+`NUM_BUTTONS`, and `busy` is high in exactly those cycles.
  - Button k is sampled in cycle T+1+k.
  - Its `debounced` change and pulse are visible in cycle T+2+k.
- Input-to-sample latency is 2 clocks through the synchronizer. An input change must precede the sampling cycle by at least 2 clocks to be seen in that scan.
- A button held steady from reset is debounced after exactly `HIST_LEN` scans. A change from a stable state takes `HIST_LEN` consecutive matching samples.
- Buttons that change together emit pulses one clock apart, in index order 0 first.

## Test plan

All scenarios use `NUM_BUTTONS`=4, `HIST_LEN`=4, `TICK_DIV`=8.

- **Reset values:** hold `reset_n` low, toggle `buttons` → all outputs 0. Release reset → `busy` high in cycles 8–11, 16–19, and so on, low elsewhere.
- **Single press:** `buttons[2]`=1 from cycle 0 → `debounced[2]` rises in cycle 35 (4th tick at 31, +2+2). `pressed[2]` is high in cycle 35 only; all other outputs stay 0.
- **Bounce rejection:** toggle `buttons[1]` so consecutive samples alternate 1,0,1,0… for 10 scans → `debounced[1]`, `pressed[1]` and `released[1]` all stay 0.
- **Release:** after the single-press scenario, drop `buttons[2]` to 0 at cycle 36 → `released[2]` pulses once in cycle 67 and `debounced[2]` falls to 0 in that cycle.
- **Simultaneous press:** all `buttons` go to 1 at cycle 0 → `pressed[0]`..`pressed[3]` pulse in cycles 33, 34, 35, 36, one per cycle, never overlapping.
- **Reset mid-scan:** with button 0 debounced, assert `reset_n` low in a SCAN cycle → all outputs clear immediately, with no pulse emitted. After release, re-pressing requires a full 4 scans before `pressed` fires.

Source files
------------

// File: rtl/button_scanner.sv
// Time-multiplexed button debouncer: synchronised inputs are sampled once per
// divided tick, and one shared history engine visits the buttons round-robin.
module button_scanner #(
  parameter int NUM_BUTTONS = 4,
  parameter int HIST_LEN    = 8,
  parameter int TICK_DIV    = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] debounced,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] released,
  output logic                   busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BUTTONS - 1);

  // A tick during SCAN would be lost, so the period must exceed one full scan.
  if (TICK_DIV <= NUM_BUTTONS + 1 || NUM_BUTTONS < 2 || HIST_LEN < 2) begin : g_bad_cfg
    $error("button_scanner: illegal parameters (need NUM_BUTTONS>=2, HIST_LEN>=2, TICK_DIV>NUM_BUTTONS+1)");
  end

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  state_t                   state, state_next;
  logic [IDX_W-1:0]         idx, idx_next;
  logic [CNT_W-1:0]         tick_cnt;
  logic                     tick;
  logic                     do_update;
  logic [NUM_BUTTONS-1:0]   sync_meta, sync;
  logic [HIST_LEN-1:0]      hist [NUM_BUTTONS];
  logic [HIST_LEN-1:0]      new_hist;
  logic                     cur_deb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= buttons;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CNT_MAX) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign tick = (tick_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    do_update  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick) begin
          idx_next   = '0;
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        do_update = 1'b1;
        if (idx == IDX_LAST) begin
          state_next = S_IDLE;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state == S_SCAN);

  assign new_hist = {hist[idx][HIST_LEN-2:0], sync[idx]};
  assign cur_deb  = debounced[idx];

  // Mixed histories fall through both branches, holding the level (hysteresis).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        hist[i] <= '0;
      end
      debounced <= '0;
      pressed   <= '0;
      released  <= '0;
    end else begin
      pressed  <= '0;
      released <= '0;
      if (do_update) begin
        hist[idx] <= new_hist;
        if ((&new_hist) && !cur_deb) begin
          debounced[idx] <= 1'b1;
          pressed[idx]   <= 1'b1;
        end else if (!(|new_hist) && cur_deb) begin
          debounced[idx] <= 1'b0;
          released[idx]  <= 1'b1;
        end
      end
    end
  end

endmodule
